// File: rtl/sgm_path_aggregator.sv
// rtl/sgm_path_aggregator.sv - one SGM path's cost aggregation, 4-stage pipeline with stall handshake
module sgm_path_aggregator #(
  parameter int DISP_RANGE = 108,
  parameter int COST_W     = 8,
  parameter int AGGR_W     = 8,
  parameter int P1         = 10,
  parameter int P2         = 120,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 10,
  parameter int SATCNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         path_start,
  input  logic [DISP_RANGE*COST_W-1:0] cost_in,
  input  logic [DISP_RANGE*AGGR_W-1:0] prev_aggr,
  input  logic [AGGR_W-1:0]            prev_min,
  input  logic [ROW_W-1:0]             row_in,
  input  logic [COL_W-1:0]             col_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DISP_RANGE*AGGR_W-1:0] cost_aggr,
  output logic [AGGR_W-1:0]            aggr_min,
  output logic [ROW_W-1:0]             row_out,
  output logic [COL_W-1:0]             col_out,
  output logic [SATCNT_W-1:0]          sat_count
);

  localparam int VW = DISP_RANGE * AGGR_W;
  localparam int CW = DISP_RANGE * COST_W;
  localparam logic [AGGR_W-1:0] AMAX = '1;

  // Sum is formed at 33 bits so any penalty value clamps instead of wrapping.
  function automatic logic [AGGR_W-1:0] sat_add(input logic [AGGR_W-1:0] x, input logic [31:0] p);
    logic [32:0] s;
    s = {1'b0, 32'(x)} + {1'b0, p};
    if (s > 33'(AMAX)) return AMAX;
    return s[AGGR_W-1:0];
  endfunction

  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  logic              s1_valid, s1_ps;
  logic [CW-1:0]     s1_cost;
  logic [VW-1:0]     s1_prev;
  logic [AGGR_W-1:0] s1_pmin;
  logic [ROW_W-1:0]  s1_row;
  logic [COL_W-1:0]  s1_col;

  logic              s2_valid, s2_ps;
  logic [VW-1:0]     s2_a, s2_b;
  logic [CW-1:0]     s2_cost;
  logic [AGGR_W-1:0] s2_pmin;
  logic [ROW_W-1:0]  s2_row;
  logic [COL_W-1:0]  s2_col;

  logic              s3_valid, s3_sat;
  logic [VW-1:0]     s3_r;
  logic [ROW_W-1:0]  s3_row;
  logic [COL_W-1:0]  s3_col;

  logic [VW-1:0]         a_next, b_next, r_next;
  logic [DISP_RANGE-1:0] sat_next;
  logic [AGGR_W-1:0]     min_next;

  for (genvar d = 0; d < DISP_RANGE; d++) begin : g_lane
    logic [AGGR_W-1:0] l1, l2, l3, l4, a, b, m, c;
    logic [AGGR_W+1:0] r;
    logic              ovf;

    assign l1 = s1_prev[d*AGGR_W +: AGGR_W];
    if (d == 0) begin : g_lo
      assign l2 = AMAX;
    end else begin : g_lo
      assign l2 = sat_add(s1_prev[(d-1)*AGGR_W +: AGGR_W], 32'(P1));
    end
    if (d == DISP_RANGE-1) begin : g_hi
      assign l3 = AMAX;
    end else begin : g_hi
      assign l3 = sat_add(s1_prev[(d+1)*AGGR_W +: AGGR_W], 32'(P1));
    end
    assign l4 = sat_add(s1_pmin, 32'(P2));
    assign a_next[d*AGGR_W +: AGGR_W] = (l1 < l2) ? l1 : l2;
    assign b_next[d*AGGR_W +: AGGR_W] = (l3 < l4) ? l3 : l4;

    // m >= prev_min always holds, so the subtraction cannot underflow.
    assign a   = s2_a[d*AGGR_W +: AGGR_W];
    assign b   = s2_b[d*AGGR_W +: AGGR_W];
    assign m   = (a < b) ? a : b;
    assign c   = AGGR_W'(s2_cost[d*COST_W +: COST_W]);
    assign r   = {2'b00, c} + {2'b00, m} - {2'b00, s2_pmin};
    assign ovf = r > {2'b00, AMAX};
    assign r_next[d*AGGR_W +: AGGR_W] = s2_ps ? c : (ovf ? AMAX : r[AGGR_W-1:0]);
    assign sat_next[d] = ~s2_ps & ovf;
  end

  always_comb begin
    min_next = AMAX;
    for (int d = 0; d < DISP_RANGE; d++) begin
      if (s3_r[d*AGGR_W +: AGGR_W] < min_next) min_next = s3_r[d*AGGR_W +: AGGR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ps     <= 1'b0;
      s1_cost   <= '0;
      s1_prev   <= '0;
      s1_pmin   <= '0;
      s1_row    <= '0;
      s1_col    <= '0;
      s2_valid  <= 1'b0;
      s2_ps     <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_cost   <= '0;
      s2_pmin   <= '0;
      s2_row    <= '0;
      s2_col    <= '0;
      s3_valid  <= 1'b0;
      s3_sat    <= 1'b0;
      s3_r      <= '0;
      s3_row    <= '0;
      s3_col    <= '0;
      out_valid <= 1'b0;
      cost_aggr <= '1;
      aggr_min  <= AMAX;
      row_out   <= '0;
      col_out   <= '0;
      sat_count <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_ps     <= path_start;
      s1_cost   <= cost_in;
      s1_prev   <= prev_aggr;
      s1_pmin   <= prev_min;
      s1_row    <= row_in;
      s1_col    <= col_in;
      s2_valid  <= s1_valid;
      s2_ps     <= s1_ps;
      s2_a      <= a_next;
      s2_b      <= b_next;
      s2_cost   <= s1_cost;
      s2_pmin   <= s1_pmin;
      s2_row    <= s1_row;
      s2_col    <= s1_col;
      s3_valid  <= s2_valid;
      s3_sat    <= |sat_next;
      s3_r      <= r_next;
      s3_row    <= s2_row;
      s3_col    <= s2_col;
      out_valid <= s3_valid;
      cost_aggr <= s3_r;
      aggr_min  <= min_next;
      row_out   <= s3_row;
      col_out   <= s3_col;
      if (s3_valid && s3_sat && (sat_count != '1)) sat_count <= sat_count + SATCNT_W'(1);
    end
  end

endmodule

// File: doc/sgm_path_aggregator.md
Name: sgm_path_aggregator

Overview:
- Parametrised successor of the single-path SGBM cost aggregation stage.
- Computes one path's aggregated cost vector per pixel: Lr(p,d) = C(p,d) + min(Lr(p-r,d), Lr(p-r,d±1)+P1, minLr(p-r)+P2) − minLr(p-r).
- Adds the P2 term, saturating arithmetic, a generic path-start flag and a valid/ready stall handshake.
- Computes the output vector minimum internally, so the min no longer comes from an external block.
- Sits between the census/cost-volume stage and the disparity selector; one instance per path direction. The caller supplies the previous pixel's vector along the path.

Parameters:
- DISP_RANGE, 108, number of disparity lanes D (≥2).
- COST_W, 8, width of each matching-cost lane.
- AGGR_W, 8, width of each aggregated-cost lane (≥COST_W); AMAX = 2^AGGR_W−1.
- P1, 10, small-change penalty.
- P2, 120, large-change penalty.
- ROW_W, 10, row tag width.
- COL_W, 10, column tag width.
- SATCNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- path_start  in  1  first pixel of a path; output = raw cost.
- cost_in  in  D*COST_W  matching cost; lane d at bits [d*COST_W +: COST_W].
- prev_aggr  in  D*AGGR_W  previous pixel's aggregated vector along the path.
- prev_min  in  AGGR_W  minimum of prev_aggr; must equal min over lanes.
- row_in  in  ROW_W  row tag.
- col_in  in  COL_W  column tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- cost_aggr  out  D*AGGR_W  aggregated vector.
- aggr_min  out  AGGR_W  min over cost_aggr lanes, same beat.
- row_out  out  ROW_W  tag passed through with the beat.
- col_out  out  COL_W  tag passed through with the beat.
- sat_count  out  SATCNT_W  number of output beats with ≥1 saturated lane; sticks at all-ones.

Behaviour:
- Reset (async, any time, including mid-pipeline):
  - All stage valid bits = 0; out_valid = 0.
  - cost_aggr = all ones; aggr_min = AMAX.
  - row_out = 0; col_out = 0; sat_count = 0.
  - In-flight beats are discarded, not flushed.
- Pipeline: 4 register stages; advance = out_ready | ~out_valid; in_ready = advance.
  - All stages, including valid bits, shift only when advance = 1; otherwise every stage holds.
  - A beat accepted (in_valid & in_ready) at edge k appears with out_valid = 1 after edge k+3 when there is no stall. Latency is 4 cycles from presentation to output visible.
  - Bubbles (in_valid = 0 with advance = 1) propagate as invalid stages.
  - out_valid stays high and the output stays stable until out_ready.
- S1: register cost_in, prev_aggr, prev_min, path_start, row/col tags.
- S2, per lane, using saturating adds clamped to AMAX:
  - l1 = prev[d].
  - l2 = prev[d−1]+P1, or AMAX for d = 0.
  - l3 = prev[d+1]+P1, or AMAX for d = D−1.
  - l4 = prev_min+P2.
  - Register a = min(l1,l2) and b = min(l3,l4).
- S3: m = min(a,b).
  - r = cost + m − prev_min, computed at AGGR_W+2 bits. No underflow is possible because m ≥ prev_min.
  - If r > AMAX, the lane is clamped to AMAX and flagged saturated.
  - If path_start, the lane is cost zero-extended and never flagged.
- S4: register cost_aggr, aggr_min (combinational min tree over S3 lanes), tags and valid.
  - sat_count increments by 1 on the S4 load of a valid beat with any flagged lane; it saturates at all-ones.
- All-AMAX prev lanes behave as "unreachable": sums stay clamped and never wrap.
- A path_start beat ignores prev_aggr and prev_min entirely.

Test Plan (D=4, COST_W=AGGR_W=8, P1=10, P2=120 unless stated):
- Basic recurrence: prev=[5,20,30,40], prev_min=5, cost=[10,10,10,10], path_start=0 -> cost_aggr=[10,20,35,45], aggr_min=10, out_valid 4 cycles after accept, tags preserved.
- P2 path: prev=[0,200,200,200], prev_min=0, cost=[0,0,0,50] -> lane3 m=min(200,210,AMAX,120)=120 -> cost_aggr=[0,10,120,170], aggr_min=0.
- Saturation: prev=[0,250,250,250], prev_min=0, cost=[250,250,250,250] -> cost_aggr=[250,255,255,255], sat_count 0->1; a second identical beat -> 2.
- path_start=1, cost=[7,3,9,1], prev=arbitrary -> cost_aggr=[7,3,9,1], aggr_min=1, sat_count unchanged.
- Backpressure: stream 6 beats with out_ready low for 3 cycles mid-stream -> in_ready low in those cycles, no beat lost or duplicated, output order and values identical to the unstalled run.
- Async reset asserted mid-stream between clock edges -> out_valid=0, cost_aggr=all ones, sat_count=0 immediately; first beat after release has latency 4.
